// File: rtl/raptor64_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : raptor64_pkg
//  Purpose  : Shared constants for the Raptor64 operand-bypass slice:
//             default datapath and register-number widths and the hard-wired
//             zero register number.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package raptor64_pkg;

    // Default widths of the stage-record fields (data and register number).
    localparam int DW_DEF   = 64;
    localparam int RW_DEF   = 5;

    // r0 reads as zero, is never forwarded and never written.
    localparam int REG_ZERO = 0;

endpackage
`default_nettype wire

// File: rtl/raptor64_operand_bypass_if.sv
`default_nettype none
// ============================================================================
//  Module   : raptor64_operand_bypass_if
//  Purpose  : Bundles the decode, register-file, execute and memory-stage
//             signals feeding the operand-bypass stage, plus its outputs.
//  Ports    : master - pipeline side (drives sources, X/M info, reads results)
//             slave  - bypass stage (reads sources, drives operands/write port)
//  Revision : 1.0 - initial release
// ============================================================================
interface raptor64_operand_bypass_if #(
    parameter int DW = raptor64_pkg::DW_DEF,
    parameter int RW = raptor64_pkg::RW_DEF
);
    logic          adv_i;
    logic [RW-1:0] d_ra_i;
    logic [RW-1:0] d_rb_i;
    logic [DW-1:0] rfo_a_i;
    logic [DW-1:0] rfo_b_i;
    logic          x_valid_i;
    logic [RW-1:0] x_rt_i;
    logic [DW-1:0] x_res_i;
    logic          x_load_i;
    logic          m_ld_done_i;
    logic [DW-1:0] m_ld_data_i;
    logic [DW-1:0] a_o;
    logic [DW-1:0] b_o;
    logic          stall_o;
    logic          w_we_o;
    logic [RW-1:0] w_rt_o;
    logic [DW-1:0] w_data_o;

    modport master (
        output adv_i, d_ra_i, d_rb_i, rfo_a_i, rfo_b_i,
               x_valid_i, x_rt_i, x_res_i, x_load_i,
               m_ld_done_i, m_ld_data_i,
        input  a_o, b_o, stall_o, w_we_o, w_rt_o, w_data_o
    );

    modport slave (
        input  adv_i, d_ra_i, d_rb_i, rfo_a_i, rfo_b_i,
               x_valid_i, x_rt_i, x_res_i, x_load_i,
               m_ld_done_i, m_ld_data_i,
        output a_o, b_o, stall_o, w_we_o, w_rt_o, w_data_o
    );
endinterface
`default_nettype wire

// File: rtl/raptor64_operand_bypass_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module   : raptor64_fwd_sel
//  Purpose  : Per-operand forwarding mux. Picks the newest value of one source
//             register from X, M, W or the register file, and flags when that
//             value is a load result that is not available yet.
//  Ports    : src/rfo           - source register and its regfile read data
//             x_*/m_*/w_*       - in-flight stage records
//             m_wait            - M holds a load whose data has not arrived
//             val/stall         - selected operand and stall term
//  Revision : 1.0 - initial release
// ============================================================================
module raptor64_fwd_sel
    import raptor64_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic [RW-1:0] src,
    input  logic [DW-1:0] rfo,
    input  logic          x_valid,
    input  logic [RW-1:0] x_rt,
    input  logic [DW-1:0] x_res,
    input  logic          x_load,
    input  logic          m_valid,
    input  logic [RW-1:0] m_rt,
    input  logic [DW-1:0] m_data,
    input  logic          m_wait,
    input  logic          w_valid,
    input  logic [RW-1:0] w_rt,
    input  logic [DW-1:0] w_data,
    output logic [DW-1:0] val,
    output logic          stall
);
    localparam logic [RW-1:0] ZERO = RW'(REG_ZERO);

    logic x_hit;
    logic m_hit;
    logic w_hit;

    // A hit already implies src != r0 because the target must be nonzero.
    assign x_hit = x_valid && (x_rt == src) && (x_rt != ZERO);
    assign m_hit = m_valid && (m_rt == src) && (m_rt != ZERO);
    assign w_hit = w_valid && (w_rt == src) && (w_rt != ZERO);

    always_comb begin
        val = rfo;
        if (src == ZERO) begin
            val = '0;
        end else if (x_hit) begin
            val = x_res;
        end else if (m_hit) begin
            val = m_data;
        end else if (w_hit) begin
            // W beats the regfile: the regfile reads before it writes.
            val = w_data;
        end
    end

    assign stall = (x_hit && x_load) || (m_hit && m_wait);

endmodule
`default_nettype wire

// File: rtl/raptor64_operand_bypass.sv
`default_nettype none
// ============================================================================
//  Module   : raptor64_operand_bypass
//  Purpose  : Operand-forwarding and result-pipeline stage for the Raptor64
//             execute datapaths. Registers forwarded operands a/b, carries X
//             results through M and W to the register-file write port, and
//             raises a load-use stall.
//  Ports    : clk_i, rst_i - clock, synchronous active-high reset
//             bus (slave)  - sources, regfile data, X/M info, operands,
//                            stall and register-file write port
//  Revision : 1.0 - initial release
// ============================================================================
module raptor64_operand_bypass
    import raptor64_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    raptor64_operand_bypass_if.slave      bus
);
    localparam logic [RW-1:0] ZERO = RW'(REG_ZERO);

    // M stage record
    logic          m_valid;
    logic [RW-1:0] m_rt;
    logic [DW-1:0] m_data;
    logic          m_load;
    // W stage record plus registered write strobe
    logic          w_valid;
    logic [RW-1:0] w_rt;
    logic [DW-1:0] w_data;
    logic          w_we;
    // execute operands
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;

    logic          m_done;
    logic          m_wait;
    logic [DW-1:0] m_fwd_data;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;
    logic          stall_a;
    logic          stall_b;
    logic          stall;

    // Load data arriving this cycle is forwarded straight away, so a
    // dependent instruction does not wait an extra cycle for M to capture it.
    assign m_done     = m_load && bus.m_ld_done_i;
    assign m_wait     = m_load && !bus.m_ld_done_i;
    assign m_fwd_data = m_done ? bus.m_ld_data_i : m_data;

    raptor64_fwd_sel #(.DW(DW), .RW(RW)) u_fwd_a (
        .src     (bus.d_ra_i),
        .rfo     (bus.rfo_a_i),
        .x_valid (bus.x_valid_i),
        .x_rt    (bus.x_rt_i),
        .x_res   (bus.x_res_i),
        .x_load  (bus.x_load_i),
        .m_valid (m_valid),
        .m_rt    (m_rt),
        .m_data  (m_fwd_data),
        .m_wait  (m_wait),
        .w_valid (w_valid),
        .w_rt    (w_rt),
        .w_data  (w_data),
        .val     (fwd_a),
        .stall   (stall_a)
    );

    raptor64_fwd_sel #(.DW(DW), .RW(RW)) u_fwd_b (
        .src     (bus.d_rb_i),
        .rfo     (bus.rfo_b_i),
        .x_valid (bus.x_valid_i),
        .x_rt    (bus.x_rt_i),
        .x_res   (bus.x_res_i),
        .x_load  (bus.x_load_i),
        .m_valid (m_valid),
        .m_rt    (m_rt),
        .m_data  (m_fwd_data),
        .m_wait  (m_wait),
        .w_valid (w_valid),
        .w_rt    (w_rt),
        .w_data  (w_data),
        .val     (fwd_b),
        .stall   (stall_b)
    );

    assign stall = stall_a || stall_b;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_valid <= 1'b0;
            m_rt    <= '0;
            m_data  <= '0;
            m_load  <= 1'b0;
            w_valid <= 1'b0;
            w_rt    <= '0;
            w_data  <= '0;
            w_we    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else if (bus.adv_i) begin
            // On a stall the operands hold while older stages keep draining.
            if (!stall) begin
                a_q <= fwd_a;
                b_q <= fwd_b;
            end
            m_valid <= bus.x_valid_i;
            m_rt    <= bus.x_rt_i;
            m_data  <= bus.x_res_i;
            m_load  <= bus.x_load_i;
            w_valid <= m_valid;
            w_rt    <= m_rt;
            w_data  <= m_fwd_data;
            w_we    <= m_valid && (m_rt != ZERO);
        end else begin
            // Frozen: stage records hold, but the write strobe must be a
            // single pulse per retiring instruction, so it drops here.
            w_we <= 1'b0;
            if (m_done) begin
                m_data <= bus.m_ld_data_i;
                m_load <= 1'b0;
            end
        end
    end

    assign bus.a_o      = a_q;
    assign bus.b_o      = b_q;
    assign bus.stall_o  = stall;
    assign bus.w_we_o   = w_we;
    assign bus.w_rt_o   = w_rt;
    assign bus.w_data_o = w_data;

endmodule
`default_nettype wire

// File: tb/tb_raptor64_operand_bypass.sv
`default_nettype none
// ============================================================================
//  Module   : tb_raptor64_operand_bypass
//  Purpose  : Directed self-checking bench for raptor64_operand_bypass.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_raptor64_operand_bypass;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    raptor64_operand_bypass_if #(.DW(64), .RW(5)) bus ();

    raptor64_operand_bypass #(.DW(64), .RW(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_x(input logic v, input logic [4:0] rt, input logic [63:0] res, input logic ld);
        bus.x_valid_i = v;
        bus.x_rt_i    = rt;
        bus.x_res_i   = res;
        bus.x_load_i  = ld;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.adv_i       = 1'b1;
        bus.d_ra_i      = '0;
        bus.d_rb_i      = '0;
        bus.rfo_a_i     = '0;
        bus.rfo_b_i     = '0;
        bus.m_ld_done_i = 1'b0;
        bus.m_ld_data_i = '0;
        set_x(1'b1, 5'd4, 64'h99, 1'b0);

        // reset held two cycles with a valid X instruction
        tick();
        tick();
        rst = 1'b0;
        set_x(1'b0, 5'd0, 64'h0, 1'b0);
        #1;
        chk("rst_a", bus.a_o, 64'h0);
        chk("rst_b", bus.b_o, 64'h0);
        chk("rst_we", {63'h0, bus.w_we_o}, 64'h0);
        chk("rst_stall", {63'h0, bus.stall_o}, 64'h0);
        tick();
        chk("rst_we_after", {63'h0, bus.w_we_o}, 64'h0);

        // back-to-back ALU forwarding from X
        set_x(1'b1, 5'd3, 64'h10, 1'b0);
        bus.d_ra_i = 5'd3;  bus.rfo_a_i = 64'hDEAD;
        bus.d_rb_i = 5'd0;  bus.rfo_b_i = 64'h77;
        #1;
        chk("b2b_stall", {63'h0, bus.stall_o}, 64'h0);
        tick();
        chk("b2b_a", bus.a_o, 64'h10);
        chk("b2b_b_r0", bus.b_o, 64'h0);
        set_x(1'b0, 5'd0, 64'h0, 1'b0);
        bus.d_ra_i = 5'd0;
        tick();
        chk("wr_we", {63'h0, bus.w_we_o}, 64'h1);
        chk("wr_rt", {59'h0, bus.w_rt_o}, 64'h3);
        chk("wr_data", bus.w_data_o, 64'h10);
        tick();
        chk("wr_pulse_end", {63'h0, bus.w_we_o}, 64'h0);

        // priority X > M > W > regfile
        bus.rfo_b_i = 64'hBAD;
        set_x(1'b1, 5'd5, 64'h3, 1'b0); tick();
        set_x(1'b1, 5'd5, 64'h2, 1'b0); tick();
        set_x(1'b1, 5'd5, 64'h1, 1'b0); bus.d_rb_i = 5'd5; tick();
        chk("prio_x", bus.b_o, 64'h1);
        bus.d_rb_i = 5'd0;
        set_x(1'b1, 5'd5, 64'h3, 1'b0); tick();
        set_x(1'b1, 5'd5, 64'h2, 1'b0); tick();
        set_x(1'b0, 5'd0, 64'h0, 1'b0); bus.d_rb_i = 5'd5; tick();
        chk("prio_m", bus.b_o, 64'h2);
        bus.d_rb_i = 5'd0;
        set_x(1'b1, 5'd5, 64'h3, 1'b0); tick();
        set_x(1'b0, 5'd0, 64'h0, 1'b0); tick();
        bus.d_rb_i = 5'd5; tick();
        chk("prio_w", bus.b_o, 64'h3);
        tick();
        chk("prio_rf", bus.b_o, 64'hBAD);
        bus.d_rb_i = 5'd0;

        // r0 never forwarded or written
        set_x(1'b1, 5'd0, 64'hFF, 1'b0);
        bus.d_ra_i = 5'd0; bus.rfo_a_i = 64'h1234;
        tick();
        chk("r0_a", bus.a_o, 64'h0);
        set_x(1'b0, 5'd0, 64'h0, 1'b0);
        tick();
        chk("r0_we_w", {63'h0, bus.w_we_o}, 64'h0);
        tick();
        chk("r0_we_next", {63'h0, bus.w_we_o}, 64'h0);

        // load-use stall, then completion forwarded the same cycle
        set_x(1'b1, 5'd7, 64'hEEEE, 1'b1);
        bus.d_ra_i = 5'd7; bus.rfo_a_i = 64'h1111;
        #1;
        chk("lu_stall_x", {63'h0, bus.stall_o}, 64'h1);
        tick();
        chk("lu_a_hold", bus.a_o, 64'h0);
        set_x(1'b0, 5'd0, 64'h0, 1'b0);
        #1;
        chk("lu_stall_m", {63'h0, bus.stall_o}, 64'h1);
        bus.m_ld_done_i = 1'b1; bus.m_ld_data_i = 64'h55;
        #1;
        chk("lu_stall_done", {63'h0, bus.stall_o}, 64'h0);
        tick();
        chk("lu_a", bus.a_o, 64'h55);
        chk("lu_we", {63'h0, bus.w_we_o}, 64'h1);
        chk("lu_rt", {59'h0, bus.w_rt_o}, 64'h7);
        chk("lu_wdata", bus.w_data_o, 64'h55);
        bus.m_ld_done_i = 1'b0; bus.m_ld_data_i = 64'h0;
        bus.d_ra_i = 5'd0;

        // load completing while frozen is captured into M
        set_x(1'b1, 5'd8, 64'hEEEE, 1'b1);
        tick();
        set_x(1'b0, 5'd0, 64'h0, 1'b0);
        bus.adv_i = 1'b0;
        bus.m_ld_done_i = 1'b1; bus.m_ld_data_i = 64'h88;
        tick();
        bus.m_ld_done_i = 1'b0; bus.m_ld_data_i = 64'h0;
        bus.d_rb_i = 5'd8;
        #1;
        chk("frz_ld_stall", {63'h0, bus.stall_o}, 64'h0);
        bus.adv_i = 1'b1;
        tick();
        chk("frz_ld_b", bus.b_o, 64'h88);
        chk("frz_ld_we", {63'h0, bus.w_we_o}, 64'h1);
        chk("frz_ld_wdata", bus.w_data_o, 64'h88);
        bus.d_rb_i = 5'd0;
        tick();

        // freeze three cycles mid-stream
        set_x(1'b1, 5'd9, 64'h900, 1'b0);
        tick();
        chk("frz_a_pre", bus.a_o, 64'h0);
        bus.adv_i = 1'b0;
        set_x(1'b1, 5'd10, 64'hA00, 1'b1);
        bus.d_ra_i = 5'd9; bus.d_rb_i = 5'd10;
        #1;
        chk("frz_stall_eval", {63'h0, bus.stall_o}, 64'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_a_hold", bus.a_o, 64'h0);
            chk("frz_we_low", {63'h0, bus.w_we_o}, 64'h0);
        end
        bus.adv_i = 1'b1;
        set_x(1'b0, 5'd0, 64'h0, 1'b0);
        bus.d_rb_i = 5'd0;
        tick();
        chk("frz_a_resume", bus.a_o, 64'h900);
        chk("frz_we_pulse", {63'h0, bus.w_we_o}, 64'h1);
        chk("frz_wrt", {59'h0, bus.w_rt_o}, 64'h9);
        chk("frz_wdata", bus.w_data_o, 64'h900);
        bus.d_ra_i = 5'd0;
        tick();
        chk("frz_we_single", {63'h0, bus.w_we_o}, 64'h0);

        // reset mid-operation discards in-flight M/W
        set_x(1'b1, 5'd11, 64'hB, 1'b0);
        bus.d_ra_i = 5'd11;
        tick();
        chk("mid_a", bus.a_o, 64'hB);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_x(1'b0, 5'd0, 64'h0, 1'b0);
        bus.d_ra_i = 5'd0;
        #1;
        chk("mid_rst_a", bus.a_o, 64'h0);
        chk("mid_rst_we", {63'h0, bus.w_we_o}, 64'h0);
        tick();
        chk("mid_rst_we2", {63'h0, bus.w_we_o}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
